// File: rtl/data_store_buffer_pkg.sv
// ============================================================================
// Module   : store_buf_pkg
// Brief    : Shared entry type, sizing constants and word-address compare
//            for the data store buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_buf_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int PTR_W     = $clog2(SB_DEPTH);

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    // Byte offset bits are ignored: the buffer tracks whole words only.
    function automatic logic word_match(input logic [SB_ADDR_W-1:0] a,
                                        input logic [SB_ADDR_W-1:0] b);
        return a[SB_ADDR_W-1:2] == b[SB_ADDR_W-1:2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_store_buffer_if.sv
// ============================================================================
// Module   : data_store_buffer_if
// Brief    : CPU load/store port plus backing-memory read/write port of the
//            data store buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // CPU side
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_in;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] data;
    logic              stall;
    logic              empty;
    // Backing memory side
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;

    modport slave (
        input  data_addr, data_in, mem_read, mem_write, mem_rd_data, mem_wr_ready,
        output data, stall, empty, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data
    );

    modport master (
        output data_addr, data_in, mem_read, mem_write, mem_rd_data, mem_wr_ready,
        input  data, stall, empty, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data
    );

endinterface

`default_nettype wire

// File: rtl/data_store_buffer_match.sv
// ============================================================================
// Module   : store_buf_match
// Brief    : Youngest-first word-address match over the store buffer entries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buf_match
    import store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  sb_entry_t            entries [DEPTH],
    input  logic [PW-1:0]        head,
    input  logic [PW-1:0]        tail,
    input  logic [SB_ADDR_W-1:0] addr,
    output logic                 hit,
    output logic [PW-1:0]        hit_idx,
    output logic                 hit_is_head
);

    logic [PW-1:0] w_idx;

    // Walk backwards from tail-1 so the first hit is the youngest store.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        w_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = tail - PW'(i + 1);
            if (!hit && entries[w_idx].valid && word_match(entries[w_idx].addr, addr)) begin
                hit     = 1'b1;
                hit_idx = w_idx;
            end
        end
    end

    assign hit_is_head = hit && (hit_idx == head);

endmodule

`default_nettype wire

// File: rtl/data_store_buffer.sv
// ============================================================================
// Module   : data_store_buffer
// Brief    : Posted-write store buffer with youngest-match load forwarding.
//            Optional in-place store coalescing: STORE_BUF_COALESCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    data_store_buffer_if.slave   bus
);

    localparam int              c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(DEPTH);

    sb_entry_t            r_entries [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_PTR_W:0]     r_count;

    logic                 w_hit;
    logic [c_PTR_W-1:0]   w_hit_idx;
    logic                 w_hit_is_head;
    logic                 w_full;
    logic                 w_deq;
    logic                 w_enq;
    logic                 w_coalesce;
    logic                 w_unused;

    store_buf_match #(
        .DEPTH (DEPTH),
        .PW    (c_PTR_W)
    ) u_match (
        .entries     (r_entries),
        .head        (r_head),
        .tail        (r_tail),
        .addr        (bus.data_addr),
        .hit         (w_hit),
        .hit_idx     (w_hit_idx),
        .hit_is_head (w_hit_is_head)
    );

    assign w_full = (r_count == c_FULL);
    assign w_deq  = (r_count != '0) && bus.mem_wr_ready;

`ifdef STORE_BUF_COALESCE_EN
    // The head may be mid-handshake with memory, so it is never rewritten.
    assign w_coalesce = bus.mem_write && w_hit && !w_hit_is_head;
    assign w_unused   = &{1'b0, bus.mem_read};
`else
    assign w_coalesce = 1'b0;
    assign w_unused   = &{1'b0, bus.mem_read, w_hit_is_head};
`endif

    assign w_enq = bus.mem_write && !w_full && !w_coalesce;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else begin
            if (w_deq) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + c_PTR_ONE;
            end
            if (w_enq) begin
                r_entries[r_tail] <= '{valid: 1'b1, addr: bus.data_addr, data: bus.data_in};
                r_tail            <= r_tail + c_PTR_ONE;
            end
            if (w_coalesce) begin
                r_entries[w_hit_idx].data <= bus.data_in;
            end
            r_count <= r_count + {{c_PTR_W{1'b0}}, w_enq} - {{c_PTR_W{1'b0}}, w_deq};
        end
    end

    assign bus.stall        = bus.mem_write && w_full && !w_coalesce;
    assign bus.empty        = (r_count == '0);
    assign bus.data         = w_hit ? r_entries[w_hit_idx].data : bus.mem_rd_data;
    assign bus.mem_rd_addr  = bus.data_addr;
    assign bus.mem_wr_valid = (r_count != '0);
    assign bus.mem_wr_addr  = r_entries[r_head].addr;
    assign bus.mem_wr_data  = r_entries[r_head].data;

endmodule

`default_nettype wire

// File: tb/tb_data_store_buffer.sv
// ============================================================================
// Module   : tb_data_store_buffer
// Brief    : Scoreboard bench for data_store_buffer (queue model of the FIFO).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    data_store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_store_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit wmatch(input logic [31:0] x, input logic [31:0] y);
        return x[31:2] == y[31:2];
    endfunction

    task automatic drive(input bit r, input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] din, input bit rdy, input logic [31:0] rdata);
        rst              = r;
        bus.mem_write    = wr;
        bus.mem_read     = rd;
        bus.data_addr    = addr;
        bus.data_in      = din;
        bus.mem_wr_ready = rdy;
        bus.mem_rd_data  = rdata;
    endtask

    // Check this cycle's outputs against the model, then advance model and clock.
    task automatic step();
        ent_t        e;
        int          j;
        bit          coal;
        bit          enq;
        bit          deq;
        logic [31:0] fwd;
        #2;
        if (rst) begin
            j = -1;
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (wmatch(q[k].a, bus.data_addr)) begin
                    j = k;
                    break;
                end
            end
            fwd = (j >= 0) ? q[j].d : bus.mem_rd_data;
`ifdef STORE_BUF_COALESCE_EN
            coal = bus.mem_write && (j > 0);
`else
            coal = 1'b0;
`endif
            check_eq("stall", 64'(bus.stall), 64'(bus.mem_write && !coal && q.size() == DEPTH));
            check_eq("wr_valid", 64'(bus.mem_wr_valid), 64'(q.size() != 0));
            check_eq("empty", 64'(bus.empty), 64'(q.size() == 0));
            check_eq("rd_addr", 64'(bus.mem_rd_addr), 64'(bus.data_addr));
            if (bus.mem_read) check_eq("load", 64'(bus.data), 64'(fwd));
            deq = bus.mem_wr_ready && (q.size() != 0);
            enq = bus.mem_write && !coal && (q.size() < DEPTH);
            if (coal) q[j].d = bus.data_in;
            if (deq) begin
                e = q.pop_front();
                check_eq("drain_addr", 64'(bus.mem_wr_addr), 64'(e.a));
                check_eq("drain_data", 64'(bus.mem_wr_data), 64'(e.d));
            end
            if (enq) q.push_back('{a: bus.data_addr, d: bus.data_in});
        end else begin
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset held with a store request pending
        drive(0, 1, 1, 32'h1000, 32'h77, 0, 32'h1234);
        step();
        #2;
        check_eq("rst_empty", 64'(bus.empty), 64'd1);
        check_eq("rst_valid", 64'(bus.mem_wr_valid), 64'd0);
        check_eq("rst_stall", 64'(bus.stall), 64'd0);
        check_eq("rst_data", 64'(bus.data), 64'h1234);
        step();
        drive(1, 0, 1, 32'h1000, 0, 0, 32'h1234);
        step();

        // Forwarding from a just-posted store
        drive(1, 1, 0, 32'h1000, 32'hAAAA, 0, 0);
        step();
        drive(1, 0, 1, 32'h1000, 0, 0, 32'h5555);
        #2;
        check_eq("t2_fwd", 64'(bus.data), 64'hAAAA);
        check_eq("t2_head", 64'(bus.mem_wr_addr), 64'h1000);
        step();

        // Fill, stall on the fifth store, dequeue-only while full
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 32'h3000 + 32'(i * 4), 32'h30 + 32'(i), 0, 0);
            step();
        end
        drive(1, 1, 0, 32'h300C, 32'h33, 0, 0);
        #2;
        check_eq("t3_stall", 64'(bus.stall), 64'd1);
        step();
        drive(1, 1, 0, 32'h300C, 32'h33, 1, 0);
        #2;
        check_eq("t6_stall", 64'(bus.stall), 64'd1);
        step();
        drive(1, 1, 0, 32'h300C, 32'h33, 0, 0);
        #2;
        check_eq("t3_accept", 64'(bus.stall), 64'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, 0, 1, 0);
            step();
        end
        check_eq("t3_empty", 64'(bus.empty), 64'd1);

        // Same word stored twice: youngest wins, drain keeps order
        drive(1, 1, 0, 32'h2000, 32'd1, 0, 0);
        step();
        drive(1, 1, 0, 32'h2002, 32'd2, 0, 0);
        step();
        drive(1, 0, 1, 32'h2000, 0, 0, 32'hDEAD);
        #2;
        check_eq("t4_fwd", 64'(bus.data), 64'd2);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 1, 0);
            step();
        end

        // Coalescing pattern (allocates in the default build)
        drive(1, 1, 0, 32'h10, 32'd1, 0, 0);  step();
        drive(1, 1, 0, 32'h20, 32'd2, 0, 0);  step();
        drive(1, 1, 0, 32'h20, 32'd3, 0, 0);  step();
        drive(1, 1, 1, 32'h10, 32'd9, 0, 0);  step();
        drive(1, 1, 1, 32'h30, 32'd4, 0, 0);  step();
        drive(1, 1, 1, 32'h40, 32'd5, 0, 0);  step();
        drive(1, 1, 1, 32'h20, 32'd6, 0, 0);  step();
        drive(1, 0, 1, 32'h20, 0, 0, 32'hBEEF); step();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, 0, 1, 0);
            step();
        end

        // Reset while draining discards everything
        drive(1, 1, 0, 32'h500, 32'h5, 0, 0); step();
        drive(1, 1, 0, 32'h504, 32'h6, 0, 0); step();
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        #2;
        check_eq("rst_drop_valid", 64'(bus.mem_wr_valid), 64'd0);
        check_eq("rst_drop_empty", 64'(bus.empty), 64'd1);
        drive(1, 0, 0, 0, 0, 0, 0);
        step();

        // Random mix over a small address window
        for (int i = 0; i < 300; i++) begin
            drive(1, ($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1,
                  32'h100 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3)),
                  $urandom, ($urandom_range(0, 2) == 0), $urandom);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 0, 1, 0);
            step();
        end
        check_eq("final_empty", 64'(bus.empty), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
